// File: rtl/candy_pkg.sv
// Shared keypad constants and the event buffer state type for the candy front end.
// Pure definitions; no timing or handshake of its own.
package candy_pkg;

  localparam int NUM_KEYS    = 4;
  localparam int KEY_COIN50  = 0;
  localparam int KEY_COIN100 = 1;
  localparam int KEY_CANCEL  = 2;
  localparam int KEY_CANDY   = 3;

  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_e;

  // Width needed to hold 0..n-1, never narrower than one bit.
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/candy_debounce.sv
// One keypad line: 2-flop synchroniser, saturating stability counter, debounced level and rise strobe.
// Level follows raw D+1 edges after sync; rise is a one-cycle strobe from registered state; no backpressure.
module candy_debounce
  import candy_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = width_of(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_raw,
  output logic level,
  output logic rise
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             stable_q, stable_d;
  logic             stable_dly_q, stable_dly_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The counter restarts on any agreement, so it only reaches CNT_MAX on an unbroken run.
  always_comb begin
    sync1_d      = key_raw;
    sync2_d      = sync1_q;
    stable_d     = stable_q;
    stable_dly_d = stable_q;
    cnt_d        = cnt_q;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      stable_d = sync2_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      stable_q     <= 1'b0;
      stable_dly_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      stable_q     <= stable_d;
      stable_dly_q <= stable_dly_d;
      cnt_q        <= cnt_d;
    end
  end

  assign level = stable_q;
  assign rise  = stable_q & ~stable_dly_q;

endmodule

// File: rtl/candy_key_conditioner.sv
// Keypad front end: per-key debounce, lowest-index arbitration, one-entry event buffer, sticky overflow.
// Press to evt_valid is D+2 edges; while full and stalled, new presses are dropped and flag overflow.
module candy_key_conditioner
  import candy_pkg::*;
#(
  parameter int NUM_KEYS        = candy_pkg::NUM_KEYS,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int KEY_W           = width_of(NUM_KEYS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] key_raw,
  output logic                evt_valid,
  output logic [KEY_W-1:0]    evt_key,
  output logic [NUM_KEYS-1:0] evt_onehot,
  input  logic                evt_ready,
  output logic [NUM_KEYS-1:0] key_level,
  output logic                overflow,
  input  logic                overflow_clr
);

  logic [NUM_KEYS-1:0] rise;

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    candy_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk    (clk),
      .rst_n  (reset),
      .key_raw(key_raw[g]),
      .level  (key_level[g]),
      .rise   (rise[g])
    );
  end

  buf_state_e          state_q, state_d;
  logic [KEY_W-1:0]    key_q, key_d;
  logic [NUM_KEYS-1:0] onehot_q, onehot_d;
  logic                ovf_q, ovf_d;

  logic                win_vld;
  logic [KEY_W-1:0]    win_idx;
  logic                multi_press;
  logic                drop;

  // Scanning downward leaves the lowest set index as the winner.
  always_comb begin
    win_idx = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (rise[i]) begin
        win_idx = KEY_W'(i);
      end
    end
    win_vld     = |rise;
    multi_press = (rise & (rise - NUM_KEYS'(1))) != '0;
  end

  always_comb begin
    state_d  = state_q;
    key_d    = key_q;
    onehot_d = onehot_q;
    drop     = multi_press;
    case (state_q)
      BUF_EMPTY: begin
        if (win_vld) begin
          state_d  = BUF_FULL;
          key_d    = win_idx;
          onehot_d = NUM_KEYS'(1) << win_idx;
        end
      end
      BUF_FULL: begin
        if (evt_ready) begin
          if (win_vld) begin
            key_d    = win_idx;
            onehot_d = NUM_KEYS'(1) << win_idx;
          end else begin
            state_d  = BUF_EMPTY;
            key_d    = '0;
            onehot_d = '0;
          end
        end else if (win_vld) begin
          drop = 1'b1;
        end
      end
      default: begin
        state_d  = BUF_EMPTY;
        key_d    = '0;
        onehot_d = '0;
      end
    endcase
    if (drop) begin
      ovf_d = 1'b1;
    end else if (overflow_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= BUF_EMPTY;
      key_q    <= '0;
      onehot_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      key_q    <= key_d;
      onehot_q <= onehot_d;
      ovf_q    <= ovf_d;
    end
  end

  assign evt_valid  = (state_q == BUF_FULL);
  assign evt_key    = key_q;
  assign evt_onehot = onehot_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_candy_key_conditioner.sv
// Randomised and directed stimulus for candy_key_conditioner, scored against a history-window reference model.
module tb_candy_key_conditioner;

  localparam int N  = 4;
  localparam int D  = 4;
  localparam int KW = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [N-1:0]  key_raw = '0;
  logic          evt_ready = 1'b1;
  logic          overflow_clr = 1'b0;
  logic          evt_valid;
  logic [KW-1:0] evt_key;
  logic [N-1:0]  evt_onehot;
  logic [N-1:0]  key_level;
  logic          overflow;

  always #5 clk = ~clk;

  candy_key_conditioner #(
    .NUM_KEYS       (N),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .key_raw     (key_raw),
    .evt_valid   (evt_valid),
    .evt_key     (evt_key),
    .evt_onehot  (evt_onehot),
    .evt_ready   (evt_ready),
    .key_level   (key_level),
    .overflow    (overflow),
    .overflow_clr(overflow_clr)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  typedef struct {
    int key;
    int start;
  } exp_t;
  exp_t sb[$];

  // Reference model: a level flips once the last D synchronised samples all disagree with it.
  bit m_s1[N], m_s2[N], m_lvl[N], m_lvl_prev[N];
  bit hist[N][$];
  bit m_full, m_ovf, m_set, m_xfer, m_diff;
  int m_win, m_npress;

  always @(posedge clk) begin
    cyc++;
    if (!reset) begin
      for (int k = 0; k < N; k++) begin
        m_s1[k] = 0; m_s2[k] = 0; m_lvl[k] = 0; m_lvl_prev[k] = 0;
        hist[k].delete();
      end
      m_full = 0;
      m_ovf  = 0;
      sb.delete();
    end else begin
      m_win = -1;
      m_npress = 0;
      for (int k = 0; k < N; k++) begin
        if (m_lvl[k] && !m_lvl_prev[k]) begin
          m_npress++;
          if (m_win < 0) m_win = k;
        end
      end
      m_set  = (m_npress > 1);
      m_xfer = m_full && evt_ready;
      if (m_win >= 0) begin
        if (!m_full || m_xfer) begin
          m_full = 1;
          sb.push_back('{key: m_win, start: cyc});
        end else begin
          m_set = 1;
        end
      end else if (m_xfer) begin
        m_full = 0;
      end
      if (m_set) m_ovf = 1;
      else if (overflow_clr) m_ovf = 0;
      for (int k = 0; k < N; k++) begin
        m_lvl_prev[k] = m_lvl[k];
        hist[k].push_back(m_s2[k]);
        if (hist[k].size() > D) void'(hist[k].pop_front());
        if (hist[k].size() == D) begin
          m_diff = 1;
          foreach (hist[k][j]) if (hist[k][j] == m_lvl[k]) m_diff = 0;
          if (m_diff) m_lvl[k] = !m_lvl[k];
        end
        m_s2[k] = m_s1[k];
        m_s1[k] = key_raw[k];
      end
    end
  end

  // Monitor: samples on the falling edge, pops the scoreboard on each transfer.
  bit mon_prev_vld = 0, mon_prev_xfer = 0;
  int n_evt = 0;
  int last_key = -1;
  logic [N-1:0] m_lvl_vec;

  always @(negedge clk) begin
    if (!reset) begin
      check("rst_evt_valid", evt_valid, 0);
      check("rst_evt_key", evt_key, 0);
      check("rst_evt_onehot", evt_onehot, 0);
      check("rst_key_level", key_level, 0);
      check("rst_overflow", overflow, 0);
      mon_prev_vld  = 0;
      mon_prev_xfer = 0;
    end else begin
      for (int k = 0; k < N; k++) m_lvl_vec[k] = m_lvl[k];
      check("key_level", key_level, m_lvl_vec);
      check("overflow", overflow, m_ovf);
      if (!evt_valid) begin
        check("onehot_idle", evt_onehot, 0);
      end else begin
        check("onehot", evt_onehot, 32'd1 << evt_key);
        if (!mon_prev_vld || mon_prev_xfer) begin
          if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_event: got key %0d, expected no event (cycle %0d)", evt_key, cyc);
          end else begin
            check("evt_key_start", evt_key, sb[0].key);
            check("evt_latency", cyc, sb[0].start);
          end
        end
        if (evt_ready) begin
          n_evt++;
          last_key = evt_key;
          if (sb.size() > 0) begin
            check("evt_key_xfer", evt_key, sb[0].key);
            void'(sb.pop_front());
          end
        end
      end
      mon_prev_vld  = evt_valid;
      mon_prev_xfer = evt_valid && evt_ready;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called just after a posedge with the key newly raised: the next posedge is E0.
  task automatic measure_latency(input string name);
    int  edges = 0;
    bit  seen  = 0;
    while (!seen && edges < 40) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (evt_valid) seen = 1;
    end
    check(name, seen ? edges : -1, D + 3);
  endtask

  int evt_base;

  initial begin
    step(3);
    reset = 1'b1;
    step(2);

    // 1: single clean press
    evt_base = n_evt;
    key_raw = 4'b0001;
    measure_latency("t1_latency");
    step(3);
    key_raw = '0;
    step(12);
    check("t1_event_count", n_evt - evt_base, 1);
    check("t1_key", last_key, 0);
    check("t1_overflow", overflow, 0);

    // 2: bouncing key 3, then held
    evt_base = n_evt;
    for (int i = 0; i < 6; i++) begin
      key_raw[3] = ~key_raw[3];
      step(2);
    end
    check("t2_no_event_while_bouncing", n_evt - evt_base, 0);
    key_raw[3] = 1'b1;
    step(12);
    key_raw = '0;
    step(12);
    check("t2_event_count", n_evt - evt_base, 1);
    check("t2_key", last_key, 3);

    // 3: simultaneous presses
    evt_base = n_evt;
    key_raw = 4'b0110;
    step(12);
    key_raw = '0;
    step(12);
    check("t3_event_count", n_evt - evt_base, 1);
    check("t3_key", last_key, 1);
    check("t3_overflow", overflow, 1);
    overflow_clr = 1'b1;
    step(1);
    overflow_clr = 1'b0;

    // 4: stalled consumer, second press dropped
    evt_ready = 1'b0;
    key_raw = 4'b0001; step(8);
    key_raw = '0;      step(8);
    key_raw = 4'b0010; step(8);
    key_raw = '0;      step(8);
    check("t4_held_valid", evt_valid, 1);
    check("t4_held_key", evt_key, 0);
    check("t4_overflow", overflow, 1);
    evt_base = n_evt;
    evt_ready = 1'b1;
    step(2);
    check("t4_drained", evt_valid, 0);
    check("t4_event_count", n_evt - evt_base, 1);
    overflow_clr = 1'b1;
    step(1);
    overflow_clr = 1'b0;

    // 5: second press lands on the transfer cycle
    evt_base = n_evt;
    key_raw = 4'b0001; step(1);
    key_raw = 4'b0011; step(12);
    key_raw = '0;      step(12);
    check("t5_event_count", n_evt - evt_base, 2);
    check("t5_last_key", last_key, 1);

    // 6: reset mid-debounce with the key held
    evt_base = n_evt;
    key_raw = 4'b0001;
    step(3);
    reset = 1'b0;
    #1;
    check("t6_rst_valid", evt_valid, 0);
    check("t6_rst_level", key_level, 0);
    step(2);
    reset = 1'b1;
    measure_latency("t6_latency_after_reset");
    step(1);
    key_raw = '0;
    step(12);
    check("t6_event_count", n_evt - evt_base, 1);
    key_raw = 4'b0110; step(12);
    key_raw = '0;      step(12);
    check("t6_overflow_set", overflow, 1);
    overflow_clr = 1'b1;
    step(1);
    overflow_clr = 1'b0;
    check("t6_overflow_clr", overflow, 0);

    // Random traffic
    repeat (400) begin
      if ($urandom_range(0, 5) == 0) key_raw = N'($urandom);
      evt_ready    = ($urandom_range(0, 3) != 0);
      overflow_clr = ($urandom_range(0, 19) == 0);
      step(1);
    end
    key_raw = '0;
    evt_ready = 1'b1;
    overflow_clr = 1'b0;
    step(30);
    check("scoreboard_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion before 200000");
    $fatal(1);
  end

endmodule
